// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/EXEC/MEM/WB control FSM for the MIPS core.
// Owns the handshake on the shared instruction/data memory port and gates the
// decoder's commit strobes so that every instruction retires exactly once.
// It stops in HALT on a jump to address zero or when a bus access times out.
module cpu_sequencer #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             waitrequest,
    input  logic             dec_data_read,
    input  logic             dec_data_write,
    input  logic             dec_reg_write,
    input  logic [3:0]       dec_byte_enable,
    input  logic             pc_next_zero,
    output logic             mem_read,
    output logic             mem_write,
    output logic [3:0]       mem_byteenable,
    output logic             addr_sel,
    output logic             ir_load,
    output logic             mdr_load,
    output logic             reg_write_enable,
    output logic             pc_write,
    output logic             active,
    output logic             bus_error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } state_t;

    // Watchdog counter only needs to reach MAX_WAIT-1; a zero MAX_WAIT disables it.
    localparam bit WATCHDOG_ON  = (MAX_WAIT > 0);
    localparam int WAIT_W       = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int LAST_WAIT_I  = (MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0;
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(LAST_WAIT_I);

    state_t            state_q;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;

    logic       rd_c;
    logic       wr_c;
    logic [3:0] be_c;
    logic       addr_c;
    logic       ir_c;
    logic       mdr_c;
    logic       commit;
    logic       stall;
    logic       timeout;
    logic       is_load;
    logic       is_store;
    state_t     after_commit;

    // A load takes precedence if the decoder ever flags both, so read and write never overlap.
    assign is_load      = dec_data_read;
    assign is_store     = dec_data_write & ~dec_data_read;
    assign after_commit = pc_next_zero ? HALT : FETCH;

    // Decode the current state into bus requests, load/commit intents and the next state.
    always_comb begin
        next_state = state_q;
        rd_c       = 1'b0;
        wr_c       = 1'b0;
        be_c       = 4'b0000;
        addr_c     = 1'b0;
        ir_c       = 1'b0;
        mdr_c      = 1'b0;
        commit     = 1'b0;
        stall      = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            FETCH: begin
                rd_c  = 1'b1;
                be_c  = 4'b1111;
                stall = waitrequest;
                if (!waitrequest) begin
                    ir_c       = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (is_load || is_store) begin
                    next_state = MEM;
                end else begin
                    commit     = 1'b1;
                    next_state = after_commit;
                end
            end
            MEM: begin
                addr_c = 1'b1;
                rd_c   = is_load;
                wr_c   = is_store;
                be_c   = dec_byte_enable;
                stall  = waitrequest;
                if (!waitrequest) begin
                    if (is_load) begin
                        mdr_c      = 1'b1;
                        next_state = WB;
                    end else begin
                        commit     = 1'b1;
                        next_state = after_commit;
                    end
                end
            end
            WB: begin
                commit     = 1'b1;
                next_state = after_commit;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
        timeout = WATCHDOG_ON && stall && (wait_cnt == LAST_WAIT);
        if (timeout) begin
            next_state = HALT;
        end
    end

    // Bus request follows the state even when frozen; loads and commits need clk_enable, and reset kills everything.
    assign mem_read         = rd_c & ~reset;
    assign mem_write        = wr_c & ~reset;
    assign mem_byteenable   = reset ? 4'b0000 : be_c;
    assign addr_sel         = addr_c & ~reset;
    assign ir_load          = ir_c & clk_enable & ~reset;
    assign mdr_load         = mdr_c & clk_enable & ~reset;
    assign pc_write         = commit & clk_enable & ~reset;
    assign reg_write_enable = commit & dec_reg_write & clk_enable & ~reset;
    assign state            = state_q;

    // Sequencer state, retire counter, watchdog and sticky status flags; everything holds while clk_enable is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            active      <= 1'b1;
            bus_error   <= 1'b0;
            instr_count <= '0;
            wait_cnt    <= '0;
        end else if (clk_enable) begin
            state_q <= next_state;
            if (commit) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            if (timeout) begin
                bus_error <= 1'b1;
            end
            if (next_state == HALT) begin
                active <= 1'b0;
            end
            if (WATCHDOG_ON && stall && !timeout) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: drives whole instructions into cpu_sequencer and compares
// every cycle against a phase plan built from each instruction's description.
module tb_cpu_sequencer;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 8;

    logic             clk;
    logic             reset;
    logic             clk_enable;
    logic             waitrequest;
    logic             dec_data_read;
    logic             dec_data_write;
    logic             dec_reg_write;
    logic [3:0]       dec_byte_enable;
    logic             pc_next_zero;
    logic             mem_read;
    logic             mem_write;
    logic [3:0]       mem_byteenable;
    logic             addr_sel;
    logic             ir_load;
    logic             mdr_load;
    logic             reg_write_enable;
    logic             pc_write;
    logic             active;
    logic             bus_error;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    cpu_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .clk_enable       (clk_enable),
        .waitrequest      (waitrequest),
        .dec_data_read    (dec_data_read),
        .dec_data_write   (dec_data_write),
        .dec_reg_write    (dec_reg_write),
        .dec_byte_enable  (dec_byte_enable),
        .pc_next_zero     (pc_next_zero),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_byteenable   (mem_byteenable),
        .addr_sel         (addr_sel),
        .ir_load          (ir_load),
        .mdr_load         (mdr_load),
        .reg_write_enable (reg_write_enable),
        .pc_write         (pc_write),
        .active           (active),
        .bus_error        (bus_error),
        .state            (state),
        .instr_count      (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       st;
        logic             rd;
        logic             wr;
        logic [3:0]       be;
        logic             as;
        logic             irl;
        logic             mdrl;
        logic             rwe;
        logic             pcw;
        logic             act;
        logic             berr;
        logic [CNT_W-1:0] cnt;
    } out_t;

    typedef enum int {K_ALU, K_LOAD, K_STORE} kind_t;

    typedef struct {
        kind_t      kind;
        logic       regw;
        logic [3:0] be;
        logic       halt;
        int         fwait;
        int         mwait;
    } instr_t;

    typedef struct {
        string            name;
        instr_t           ins;
        int               cycles;
        int               pcw;
        int               rwe;
        logic [2:0]       st;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    localparam int P_FSTALL = 0;
    localparam int P_FDONE  = 1;
    localparam int P_EXMEM  = 2;
    localparam int P_EXCOM  = 3;
    localparam int P_MSTALL = 4;
    localparam int P_MDONE  = 5;
    localparam int P_WB     = 6;
    localparam int P_HALT   = 7;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] m_count;
    logic             m_halted;
    logic             m_berr;
    bit               freeze_en;
    int               cyc_cnt;
    int               pcw_seen;
    int               rwe_seen;
    int               irl_seen;

    function automatic out_t sample_dut();
        out_t o;
        o.st   = state;
        o.rd   = mem_read;
        o.wr   = mem_write;
        o.be   = mem_byteenable;
        o.as   = addr_sel;
        o.irl  = ir_load;
        o.mdrl = mdr_load;
        o.rwe  = reg_write_enable;
        o.pcw  = pc_write;
        o.act  = active;
        o.berr = bus_error;
        o.cnt  = instr_count;
        return o;
    endfunction

    // Expected outputs for one phase of an instruction, written from the sequencing rules.
    function automatic out_t expect_for(input int ph, input instr_t ins);
        out_t o;
        o      = '0;
        o.act  = 1'b1;
        o.berr = m_berr;
        o.cnt  = m_count;
        case (ph)
            P_FSTALL: begin o.st = 3'd0; o.rd = 1'b1; o.be = 4'hF; end
            P_FDONE:  begin o.st = 3'd0; o.rd = 1'b1; o.be = 4'hF; o.irl = 1'b1; end
            P_EXMEM:  begin o.st = 3'd1; end
            P_EXCOM:  begin o.st = 3'd1; o.pcw = 1'b1; o.rwe = ins.regw; end
            P_MSTALL, P_MDONE: begin
                o.st = 3'd2;
                o.as = 1'b1;
                o.rd = (ins.kind == K_LOAD);
                o.wr = (ins.kind == K_STORE);
                o.be = ins.be;
                if (ph == P_MDONE) begin
                    if (ins.kind == K_LOAD) begin
                        o.mdrl = 1'b1;
                    end else begin
                        o.pcw = 1'b1;
                        o.rwe = ins.regw;
                    end
                end
            end
            P_WB:     begin o.st = 3'd3; o.pcw = 1'b1; o.rwe = ins.regw; end
            default:  begin o.st = 3'd4; o.act = 1'b0; end
        endcase
        return o;
    endfunction

    task automatic checkOutput(input out_t exp, input string name);
        out_t got;
        got = sample_dut();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h required %h (state %0d/%0d count %0d/%0d)",
                     name, got, exp, got.st, exp.st, got.cnt, exp.cnt);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // One cycle: drive the instruction's decoder view, then compare just after the falling edge.
    task automatic applyStimulus(input instr_t ins, input int ph, input logic wr, input bit frozen);
        out_t exp;
        @(negedge clk);
        clk_enable      = !frozen;
        waitrequest     = wr;
        dec_data_read   = (ins.kind == K_LOAD);
        dec_data_write  = (ins.kind == K_STORE);
        dec_reg_write   = ins.regw;
        dec_byte_enable = ins.be;
        pc_next_zero    = ins.halt;
        #1;
        exp = expect_for(ph, ins);
        if (frozen) begin
            exp.irl  = 1'b0;
            exp.mdrl = 1'b0;
            exp.pcw  = 1'b0;
            exp.rwe  = 1'b0;
            checkOutput(exp, "frozen_cycle");
        end else begin
            checkOutput(exp, $sformatf("phase%0d", ph));
            cyc_cnt++;
            if (pc_write) pcw_seen++;
            if (reg_write_enable) rwe_seen++;
            if (ir_load) irl_seen++;
            if (exp.pcw) m_count++;
        end
    endtask

    task automatic step_cycle(input instr_t ins, input int ph, input logic wr);
        if (freeze_en && ($urandom_range(0, 5) == 0)) begin
            applyStimulus(ins, ph, 1'($urandom_range(0, 1)), 1'b1);
        end
        applyStimulus(ins, ph, wr, 1'b0);
    endtask

    // Plan an instruction as FETCH stalls, FETCH, EXEC, MEM stalls, MEM, WB and walk it cycle by cycle.
    task automatic run_instr(input instr_t ins);
        int stalls;
        cyc_cnt  = 0;
        pcw_seen = 0;
        rwe_seen = 0;
        irl_seen = 0;
        stalls   = 0;
        for (int i = 0; i < ins.fwait; i++) begin
            step_cycle(ins, P_FSTALL, 1'b1);
            stalls++;
            if (stalls == MAX_WAIT) begin
                m_berr   = 1'b1;
                m_halted = 1'b1;
                return;
            end
        end
        step_cycle(ins, P_FDONE, 1'b0);
        if (ins.kind == K_ALU) begin
            step_cycle(ins, P_EXCOM, 1'($urandom_range(0, 1)));
            if (ins.halt) m_halted = 1'b1;
            return;
        end
        step_cycle(ins, P_EXMEM, 1'($urandom_range(0, 1)));
        stalls = 0;
        for (int i = 0; i < ins.mwait; i++) begin
            step_cycle(ins, P_MSTALL, 1'b1);
            stalls++;
            if (stalls == MAX_WAIT) begin
                m_berr   = 1'b1;
                m_halted = 1'b1;
                return;
            end
        end
        step_cycle(ins, P_MDONE, 1'b0);
        if (ins.kind == K_STORE) begin
            if (ins.halt) m_halted = 1'b1;
            return;
        end
        step_cycle(ins, P_WB, 1'($urandom_range(0, 1)));
        if (ins.halt) m_halted = 1'b1;
    endtask

    task automatic halt_check(input int n);
        instr_t ins;
        for (int i = 0; i < n; i++) begin
            ins.kind  = kind_t'($urandom_range(0, 2));
            ins.regw  = 1'($urandom_range(0, 1));
            ins.be    = 4'($urandom_range(0, 15));
            ins.halt  = 1'($urandom_range(0, 1));
            ins.fwait = 0;
            ins.mwait = 0;
            applyStimulus(ins, P_HALT, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic do_reset();
        out_t exp;
        @(negedge clk);
        reset          = 1'b1;
        clk_enable     = 1'b1;
        waitrequest    = 1'b0;
        dec_data_read  = 1'b1;
        dec_data_write = 1'b0;
        #1;
        exp     = '0;
        exp.act = 1'b1;
        checkOutput(exp, "reset_values");
        @(negedge clk);
        reset      = 1'b0;
        clk_enable = 1'b0;
        m_count    = '0;
        m_halted   = 1'b0;
        m_berr     = 1'b0;
    endtask

    // Directed table, watchdog and freeze/reset sequences, then a randomized instruction stream.
    initial begin
        vec_t   vecs[6];
        instr_t ins;
        out_t   exp;

        reset           = 1'b1;
        clk_enable      = 1'b0;
        waitrequest     = 1'b0;
        dec_data_read   = 1'b0;
        dec_data_write  = 1'b0;
        dec_reg_write   = 1'b0;
        dec_byte_enable = 4'h0;
        pc_next_zero    = 1'b0;
        freeze_en       = 1'b0;
        m_count         = '0;
        m_halted        = 1'b0;
        m_berr          = 1'b0;

        vecs[0] = '{"addu",      '{K_ALU,   1'b1, 4'hF, 1'b0, 0, 0}, 2, 1, 1, 3'd0, 8'd1};
        vecs[1] = '{"lw_wait3",  '{K_LOAD,  1'b1, 4'hF, 1'b0, 0, 3}, 7, 1, 1, 3'd0, 8'd2};
        vecs[2] = '{"sb",        '{K_STORE, 1'b0, 4'h1, 1'b0, 0, 0}, 3, 1, 0, 3'd0, 8'd3};
        vecs[3] = '{"lw_fwait2", '{K_LOAD,  1'b1, 4'hC, 1'b0, 2, 0}, 6, 1, 1, 3'd0, 8'd4};
        vecs[4] = '{"alu_fwait3",'{K_ALU,   1'b0, 4'hF, 1'b0, 3, 0}, 5, 1, 0, 3'd0, 8'd5};
        vecs[5] = '{"jr_zero",   '{K_ALU,   1'b0, 4'hF, 1'b1, 0, 0}, 2, 1, 0, 3'd4, 8'd6};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_instr(vecs[i].ins);
            @(posedge clk);
            #1;
            checkValue({vecs[i].name, "_cycles"}, cyc_cnt, vecs[i].cycles);
            checkValue({vecs[i].name, "_pc_write"}, pcw_seen, vecs[i].pcw);
            checkValue({vecs[i].name, "_reg_write"}, rwe_seen, vecs[i].rwe);
            checkValue({vecs[i].name, "_state"}, int'(state), int'(vecs[i].st));
            checkValue({vecs[i].name, "_count"}, int'(instr_count), int'(vecs[i].cnt));
        end
        checkValue("jr_active", int'(active), 0);
        halt_check(20);

        // Watchdog in FETCH: four stall cycles end in HALT with bus_error and no IR load.
        do_reset();
        ins = '{K_ALU, 1'b1, 4'hF, 1'b0, MAX_WAIT, 0};
        run_instr(ins);
        @(posedge clk);
        #1;
        checkValue("wd_fetch_cycles", cyc_cnt, 4);
        checkValue("wd_fetch_ir_load", irl_seen, 0);
        checkValue("wd_fetch_state", int'(state), 4);
        checkValue("wd_fetch_bus_error", int'(bus_error), 1);
        halt_check(5);

        // Watchdog in MEM for a store: no commit happens.
        do_reset();
        ins = '{K_STORE, 1'b0, 4'h3, 1'b0, 0, MAX_WAIT};
        run_instr(ins);
        @(posedge clk);
        #1;
        checkValue("wd_mem_pc_write", pcw_seen, 0);
        checkValue("wd_mem_state", int'(state), 4);
        checkValue("wd_mem_bus_error", int'(bus_error), 1);
        checkValue("wd_mem_count", int'(instr_count), 0);
        halt_check(3);

        // Freeze a load in MEM for five cycles, finish it, then reset in the middle of the next FETCH.
        do_reset();
        ins = '{K_LOAD, 1'b1, 4'hF, 1'b0, 0, 0};
        applyStimulus(ins, P_FDONE, 1'b0, 1'b0);
        applyStimulus(ins, P_EXMEM, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(ins, P_MSTALL, 1'($urandom_range(0, 1)), 1'b1);
        end
        applyStimulus(ins, P_MDONE, 1'b0, 1'b0);
        applyStimulus(ins, P_WB, 1'b0, 1'b0);
        applyStimulus(ins, P_FSTALL, 1'b1, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        exp     = '0;
        exp.act = 1'b1;
        checkOutput(exp, "reset_mid_fetch");
        @(negedge clk);
        reset      = 1'b0;
        clk_enable = 1'b0;
        m_count    = '0;
        m_halted   = 1'b0;
        m_berr     = 1'b0;

        // Random instruction mix with random stalls and freezes; long enough to wrap the counter.
        freeze_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            ins.kind  = kind_t'($urandom_range(0, 2));
            ins.regw  = 1'($urandom_range(0, 1));
            ins.be    = 4'($urandom_range(1, 15));
            ins.halt  = 1'b0;
            ins.fwait = $urandom_range(0, MAX_WAIT - 1);
            ins.mwait = $urandom_range(0, MAX_WAIT - 1);
            run_instr(ins);
        end
        @(posedge clk);
        #1;
        checkValue("random_count", int'(instr_count), int'(m_count));
        ins = '{K_STORE, 1'b0, 4'h8, 1'b1, 1, 1};
        run_instr(ins);
        freeze_en = 1'b0;
        halt_check(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
